// File: rtl/codec_ctrl_responder.sv
// rtl/codec_ctrl_responder.sv - SPI control-port responder with shadow codec register map
module codec_ctrl_responder #(
   parameter int         SYNC_STAGES = 2,
   parameter int         NUM_REGS    = 10,
   parameter logic [6:0] RESET_ADDR  = 7'h0F
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       spi_sck,
   input  logic       spi_mosi,
   input  logic       cs,
   input  logic [6:0] rd_addr,
   output logic [8:0] rd_data,
   output logic       wr_stb,
   output logic [6:0] wr_addr,
   output logic [8:0] wr_data,
   output logic       frame_err,
   output logic [7:0] frame_count,
   output logic       active
);

   localparam int         AW     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [6:0] NREGS7 = 7'(NUM_REGS);

   typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

   state_t state, next_state;

   logic [SYNC_STAGES-1:0] sck_sync, mosi_sync, cs_sync;
   logic [SYNC_STAGES:0]   settle;
   logic                   sck_prev, cs_prev;
   logic                   sck_s, mosi_s, cs_s;
   logic                   sck_rise, cs_fall, settled;
   logic                   fall_pending;
   logic                   start;
   logic [15:0]            shift;
   logic [4:0]             bit_cnt;
   logic [8:0]             regs [NUM_REGS];

   function automatic logic [8:0] reg_default(input int idx);
      case (idx)
         0, 1:    reg_default = 9'h097;
         2, 3:    reg_default = 9'h079;
         4:       reg_default = 9'h00A;
         5:       reg_default = 9'h008;
         6:       reg_default = 9'h09F;
         7:       reg_default = 9'h00A;
         default: reg_default = 9'h000;
      endcase
   endfunction

   assign sck_s    = sck_sync[SYNC_STAGES-1];
   assign mosi_s   = mosi_sync[SYNC_STAGES-1];
   assign cs_s     = cs_sync[SYNC_STAGES-1];
   assign settled  = settle[SYNC_STAGES];
   assign sck_rise = sck_s & ~sck_prev;
   // Falls are ignored until the synchronizers hold real input samples, so a
   // cs already low when reset releases does not look like a new frame.
   assign cs_fall  = settled & cs_prev & ~cs_s;

   // Input synchronizers, edge history and post-reset settle tracker
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sck_sync  <= '0;
         mosi_sync <= '0;
         cs_sync   <= '1;
         settle    <= '0;
         sck_prev  <= 1'b0;
         cs_prev   <= 1'b1;
      end else begin
         sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
         settle    <= {settle[SYNC_STAGES-1:0], 1'b1};
         sck_prev  <= sck_s;
         cs_prev   <= cs_s;
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= next_state;
   end

   // FSM next state and commit strobes
   always_comb begin
      next_state = state;
      start      = 1'b0;
      wr_stb     = 1'b0;
      frame_err  = 1'b0;
      case (state)
         IDLE: begin
            if (cs_fall || fall_pending) begin
               start      = 1'b1;
               next_state = SHIFT;
            end
         end
         SHIFT: begin
            if (cs_s) next_state = COMMIT;
         end
         COMMIT: begin
            next_state = IDLE;
            if (bit_cnt == 5'd16) wr_stb    = 1'b1;
            else                  frame_err = 1'b1;
         end
         default: next_state = IDLE;
      endcase
   end

   // Remember a cs fall that lands in COMMIT so the next frame still starts
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                            fall_pending <= 1'b0;
      else if (state == COMMIT && cs_fall)     fall_pending <= 1'b1;
      else if (state == IDLE)                  fall_pending <= 1'b0;
   end

   // Shift register and saturating bit counter; sck edges coinciding with cs rise are dropped
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shift   <= '0;
         bit_cnt <= '0;
      end else if (start) begin
         shift   <= '0;
         bit_cnt <= '0;
      end else if (state == SHIFT && !cs_s && sck_rise) begin
         shift <= {shift[14:0], mosi_s};
         if (bit_cnt != 5'd17) bit_cnt <= bit_cnt + 5'd1;
      end
   end

   // Last valid frame and frame counter
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_addr     <= '0;
         wr_data     <= '0;
         frame_count <= '0;
      end else if (wr_stb) begin
         wr_addr     <= shift[15:9];
         wr_data     <= shift[8:0];
         frame_count <= frame_count + 8'd1;
      end
   end

   // Shadow register map; the reset address takes priority over a mapped write
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= reg_default(i);
      end else if (wr_stb) begin
         if (shift[15:9] == RESET_ADDR) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= reg_default(i);
         end else if (shift[15:9] < NREGS7) begin
            regs[shift[9 +: AW]] <= shift[8:0];
         end
      end
   end

   // Registered readback; unmapped addresses read zero
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                rd_data <= '0;
      else if (rd_addr < NREGS7)   rd_data <= regs[rd_addr[AW-1:0]];
      else                         rd_data <= '0;
   end

   generate
      if (NUM_REGS > 9) begin : g_active
         assign active = regs[9][0];
      end else begin : g_no_active
         assign active = 1'b0;
      end
   endgenerate

endmodule

// File: tb/tb_codec_ctrl_responder.sv
// tb/tb_codec_ctrl_responder.sv - directed self-checking bench for codec_ctrl_responder
module tb_codec_ctrl_responder;

   logic       clk;
   logic       reset_n;
   logic       spi_sck;
   logic       spi_mosi;
   logic       cs;
   logic [6:0] rd_addr;
   logic [8:0] rd_data;
   logic       wr_stb;
   logic [6:0] wr_addr;
   logic [8:0] wr_data;
   logic       frame_err;
   logic [7:0] frame_count;
   logic       active;

   int checks   = 0;
   int failures = 0;
   int stb_cnt  = 0;
   int err_cnt  = 0;

   logic [8:0] defaults [10];
   logic [8:0] model    [10];

   codec_ctrl_responder dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .spi_sck     (spi_sck),
      .spi_mosi    (spi_mosi),
      .cs          (cs),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .wr_stb      (wr_stb),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .frame_err   (frame_err),
      .frame_count (frame_count),
      .active      (active)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse counters sampled on the falling edge
   always @(negedge clk) begin
      if (wr_stb)    stb_cnt++;
      if (frame_err) err_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic read_chk(input int a, input logic [8:0] e, input string tag);
      @(negedge clk);
      rd_addr = 7'(a);
      @(negedge clk);
      check(tag, 32'(rd_data), 32'(e));
   endtask

   task automatic send_bits(input logic [31:0] w, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         spi_mosi = w[i];
         #40 spi_sck = 1'b1;
         #40 spi_sck = 1'b0;
      end
   endtask

   // SCLK at clk/8; cs stays high for gap+1 clocks afterwards
   task automatic send_frame(input logic [31:0] w, input int n, input int gap);
      @(negedge clk);
      cs = 1'b0;
      #40;
      send_bits(w, n);
      #40 cs = 1'b1;
      repeat (gap) @(negedge clk);
   endtask

   initial begin
      int s0, e0;
      logic [8:0] d;
      logic [8:0] bb_data [11];

      defaults = '{9'h097, 9'h097, 9'h079, 9'h079, 9'h00A, 9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000};
      model    = defaults;

      reset_n  = 1'b0;
      spi_sck  = 1'b0;
      spi_mosi = 1'b0;
      cs       = 1'b1;
      rd_addr  = '0;
      #1;
      check("rst_wr_stb", 32'(wr_stb), 0);
      check("rst_frame_err", 32'(frame_err), 0);
      check("rst_rd_data", 32'(rd_data), 0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);

      // Defaults after reset
      for (int i = 0; i < 10; i++) read_chk(i, defaults[i], $sformatf("rst_r%0d", i));
      check("rst_frame_count", 32'(frame_count), 0);
      check("rst_active", 32'(active), 0);
      check("rst_wr_addr", 32'(wr_addr), 0);

      // Single write to R9
      send_frame(32'h1201, 16, 10);
      check("f1_stb", 32'(stb_cnt), 1);
      check("f1_wr_addr", 32'(wr_addr), 32'h09);
      check("f1_wr_data", 32'(wr_data), 32'h001);
      check("f1_active", 32'(active), 1);
      check("f1_count", 32'(frame_count), 1);
      read_chk(9, 9'h001, "f1_r9");

      // Write R6 then restore defaults via the reset address
      send_frame(32'h0C5A, 16, 10);
      read_chk(6, 9'h05A, "f2_r6");
      send_frame(32'h1E00, 16, 10);
      read_chk(6, 9'h09F, "f3_r6");
      read_chk(9, 9'h000, "f3_r9");
      check("f3_active", 32'(active), 0);
      check("f3_wr_addr", 32'(wr_addr), 32'h0F);
      check("f3_count", 32'(frame_count), 3);
      check("f3_stb", 32'(stb_cnt), 3);

      // Short and long frames aimed at R4 (0x09FF = addr 4, data 0x1FF)
      send_frame(32'h09FF >> 1, 15, 10);
      send_frame((32'h09FF << 1) | 32'h1, 17, 10);
      check("bad_err", 32'(err_cnt), 2);
      check("bad_stb", 32'(stb_cnt), 3);
      check("bad_count", 32'(frame_count), 3);
      read_chk(4, 9'h00A, "bad_r4");

      // Back-to-back frames to every register plus unmapped 0x0B
      for (int i = 0; i < 10; i++) bb_data[i] = 9'((i * 37 + 5) & 32'h1FF);
      bb_data[10] = 9'h1AB;
      s0 = stb_cnt;
      for (int i = 0; i < 11; i++) begin
         logic [6:0] a;
         a = (i < 10) ? 7'(i) : 7'h0B;
         send_frame({16'h0, a, bb_data[i]}, 16, 1);
      end
      repeat (10) @(negedge clk);
      check("b2b_stb", 32'(stb_cnt - s0), 11);
      check("b2b_count", 32'(frame_count), 14);
      check("b2b_wr_addr", 32'(wr_addr), 32'h0B);
      check("b2b_wr_data", 32'(wr_data), 32'h1AB);
      for (int i = 0; i < 10; i++) begin
         model[i] = bb_data[i];
         read_chk(i, model[i], $sformatf("b2b_r%0d", i));
      end
      read_chk(11, 9'h000, "b2b_unmapped");
      check("b2b_active", 32'(active), 32'(model[9][0]));

      // Reset after 8 bits of a frame, finish it with cs still low
      s0 = stb_cnt;
      e0 = err_cnt;
      @(negedge clk);
      cs = 1'b0;
      #40;
      send_bits(32'h0A, 8);
      reset_n = 1'b0;
      #30 reset_n = 1'b1;
      #40;
      send_bits(32'h55, 8);
      #40 cs = 1'b1;
      repeat (10) @(negedge clk);
      check("mid_stb", 32'(stb_cnt - s0), 0);
      check("mid_err", 32'(err_cnt - e0), 0);
      check("mid_count", 32'(frame_count), 0);
      read_chk(5, defaults[5], "mid_r5");
      read_chk(0, defaults[0], "mid_r0");
      send_frame(32'h0A55, 16, 10);
      check("post_stb", 32'(stb_cnt - s0), 1);
      check("post_count", 32'(frame_count), 1);
      read_chk(5, 9'h055, "post_r5");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
